wave_loader: RTL and testbench
==============================

WAVE_LOADER -- requirements
Module: wave_loader

Interface
REQ-001 Parameter N, default 3, number of 12-bit samples in the waveform table (legal 1..4096).
REQ-002 clk  input  1  clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  single-cycle request to begin loading a full table.
REQ-005 din  input  8  serial byte stream carrying sample data.
REQ-006 din_valid  input  1  din holds a valid byte this cycle.
REQ-007 din_ready  output  1  block accepts din this cycle; a byte transfers when din_valid and din_ready are both 1.
REQ-008 we  output  1  sample RAM write enable, one-cycle pulse per sample.
REQ-009 waddr  output  12  sample RAM write address, zero-extended from a clogb2(N)-bit counter.
REQ-010 wdata  output  12  sample RAM write data.
REQ-011 busy  output  1  load in progress.
REQ-012 done  output  1  one-cycle pulse when the last sample is written.

Function
REQ-013 The FSM SHALL have states IDLE, HI, LO, WR, DONE.
REQ-014 IDLE: busy=0, din_ready=0; start=1 SHALL move to HI on the next edge, with the address counter cleared to 0.
REQ-015 HI: din_ready=1, busy=1; on transfer, din[3:0] SHALL be latched as wdata[11:8] (din[7:4] ignored) and the state SHALL move to LO.
REQ-016 LO: din_ready=1, busy=1; on transfer, din[7:0] SHALL be latched as wdata[7:0] and the state SHALL move to WR.
REQ-017 HI/LO with din_valid=0 SHALL hold state, data and address indefinitely.
REQ-018 WR: we=1 for exactly one cycle, din_ready=0, waddr=current counter, wdata=assembled sample.
REQ-019 From WR: counter==N-1 -> DONE; otherwise counter+1 and -> HI.
REQ-020 DONE: done=1 for exactly one cycle, busy=0, then -> IDLE; waddr and wdata SHALL hold the last written values.
REQ-021 start asserted in any state other than IDLE SHALL be ignored.
REQ-022 Counter width SHALL be clogb2(N) bits, never exceeding N-1; for N=1 the table SHALL complete after a single sample with waddr=0.
REQ-023 Minimum throughput: 3 cycles per sample (HI, LO, WR) with din_valid held high; a full load takes 3N cycles from first HI to last WR.
REQ-024 we and din_ready SHALL never be high in the same cycle.

Reset
REQ-025 rst=1 SHALL immediately force state IDLE, counter=0, wdata=0, we=0, din_ready=0, busy=0, done=0.
REQ-026 rst asserted mid-load SHALL discard any partial sample without a write; after release the block SHALL wait for a new start.

Verification
REQ-027 N=3, start, bytes 0x0A,0xBC,0x01,0x23,0xF4,0x56 streamed back-to-back -> writes (0,0xABC),(1,0x123),(2,0x456) on cycles 3,6,9 after start; done pulses cycle 10.
REQ-028 N=3, din_valid toggled 1/0 every cycle -> same three writes, correct data, no extra we pulses, din_ready held through gaps.
REQ-029 Start pulsed again during load (after first sample) -> ignored; exactly 3 writes and one done pulse.
REQ-030 rst asserted after the HI byte of sample 1 -> all outputs 0 immediately, no write to address 1; fresh start reloads from address 0.
REQ-031 N=1, bytes 0xFF,0xFF -> single write (0,0xFFF), done next cycle; N=4096 full load -> last write at waddr=0xFFF, no wrap before done.

Source files
------------

// File: rtl/wave_loader.sv
// Wave loader: assembles 12-bit samples from pairs of serial bytes (high nibble, then low byte)
// and writes them sequentially into a sample RAM, pulsing done after the last one.
module wave_loader #(
  parameter int unsigned N = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  din,
  input  logic        din_valid,
  output logic        din_ready,
  output logic        we,
  output logic [11:0] waddr,
  output logic [11:0] wdata,
  output logic        busy,
  output logic        done
);

  // A single-entry table still needs one counter bit to hold address 0.
  localparam int unsigned CW   = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HI,
    S_LO,
    S_WR,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [11:0]   data_q, data_d;
  logic          din_ready_q, din_ready_d;
  logic          we_q, we_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          xfer;

  assign xfer = din_valid & din_ready_q;

  // Next-state, datapath and output decode; outputs are registered from the next state.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    data_d      = data_q;
    din_ready_d = 1'b0;
    we_d        = 1'b0;
    busy_d      = 1'b0;
    done_d      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_HI;
          cnt_d   = '0;
        end
      end
      S_HI: begin
        if (xfer) begin
          data_d[11:8] = din[3:0];
          state_d      = S_LO;
        end
      end
      S_LO: begin
        if (xfer) begin
          data_d[7:0] = din;
          state_d     = S_WR;
        end
      end
      S_WR: begin
        if (cnt_q == LAST) begin
          state_d = S_DONE;
        end else begin
          cnt_d   = cnt_q + CW'(1);
          state_d = S_HI;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    din_ready_d = (state_d == S_HI) || (state_d == S_LO);
    we_d        = (state_d == S_WR);
    busy_d      = (state_d == S_HI) || (state_d == S_LO) || (state_d == S_WR);
    done_d      = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      data_q      <= '0;
      din_ready_q <= 1'b0;
      we_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      data_q      <= data_d;
      din_ready_q <= din_ready_d;
      we_q        <= we_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign din_ready = din_ready_q;
  assign we        = we_q;
  assign waddr     = 12'(cnt_q);
  assign wdata     = data_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_wave_loader.sv
// Bench for wave_loader: three instances (N=3, N=1, N=4096) driven with random byte streams,
// each with a write/done scoreboard fed by the stimulus and drained by a monitor.
`timescale 1ns/1ps
module tb_wave_loader;

  typedef struct {
    int addr;
    int data;
    int cyc;
  } wr_t;

  int n_err = 0;
  int n_chk = 0;
  int cyc   = 0;
  logic clk = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  for (genvar k = 0; k < 3; k++) begin : g
    localparam int NS = (k == 0) ? 3 : (k == 1) ? 1 : 4096;

    logic        rst, start, din_valid, din_ready, we, busy, done;
    logic [7:0]  din;
    logic [11:0] waddr, wdata;
    logic [7:0]  bytes [2*NS];
    wr_t         wq [$];
    int          dq [$];
    int          n_done    = 0;
    int          done_cyc  = 0;
    int          last_data = 0;
    bit          fin       = 1'b0;
    string       nm;

    wave_loader #(.N(NS)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .din       (din),
      .din_valid (din_valid),
      .din_ready (din_ready),
      .we        (we),
      .waddr     (waddr),
      .wdata     (wdata),
      .busy      (busy),
      .done      (done)
    );

    // Monitor: every write and done pulse must match the head of its queue.
    always @(negedge clk) begin
      wr_t e;
      int  dc;
      if (!rst) begin
        if (we) begin
          check({nm, " we_with_din_ready"}, int'(din_ready), 0);
          check({nm, " write_expected"}, int'(wq.size() > 0), 1);
          if (wq.size() > 0) begin
            e = wq.pop_front();
            check({nm, " waddr"}, int'(waddr), e.addr);
            check({nm, " wdata"}, int'(wdata), e.data);
            check({nm, " write_cycle"}, cyc, e.cyc);
            last_data = e.data;
          end
        end
        if (done) begin
          n_done++;
          done_cyc = cyc;
          check({nm, " done_expected"}, int'(dq.size() > 0), 1);
          if (dq.size() > 0) begin
            dc = dq.pop_front();
            check({nm, " done_cycle"}, cyc, dc);
          end
          check({nm, " done_busy"}, int'(busy), 0);
          check({nm, " done_waddr_hold"}, int'(waddr), NS - 1);
          check({nm, " done_wdata_hold"}, int'(wdata), last_data);
        end
      end
    end

    task automatic check_zero(input string tag);
      check({nm, " ", tag, "_we"}, int'(we), 0);
      check({nm, " ", tag, "_din_ready"}, int'(din_ready), 0);
      check({nm, " ", tag, "_busy"}, int'(busy), 0);
      check({nm, " ", tag, "_done"}, int'(done), 0);
      check({nm, " ", tag, "_waddr"}, int'(waddr), 0);
      check({nm, " ", tag, "_wdata"}, int'(wdata), 0);
    endtask

    task automatic fill_rand();
      foreach (bytes[i]) bytes[i] = 8'($urandom);
    endtask

    task automatic reset_mid();
      rst       = 1'b1;
      start     = 1'b0;
      din_valid = 1'b0;
      #1;
      check_zero("mid_reset");
      @(negedge clk);
      rst = 1'b0;
      repeat (8) @(negedge clk);
      check({nm, " post_reset_busy"}, int'(busy), 0);
      check({nm, " post_reset_pending"}, wq.size() + dq.size(), 0);
      wq.delete();
      dq.delete();
    endtask

    // mode: 0 back-to-back, 1 valid toggling, 2 random valid; rst_at > 0 resets after that many bytes.
    task automatic load(input int mode, input int rst_at, input bit restart);
      int idx    = 0;
      int budget = 0;
      int scyc;
      int d0;
      bit v      = 1'b0;
      d0 = n_done;
      @(negedge clk);
      start = 1'b1;
      scyc  = cyc;
      @(negedge clk);
      start = 1'b0;
      while (idx < 2 * NS) begin
        case (mode)
          0:       v = 1'b1;
          1:       v = ~v;
          default: v = 1'($urandom_range(0, 1));
        endcase
        din_valid = v;
        din       = v ? bytes[idx] : 8'($urandom);
        start     = restart && (idx == 2);
        if (v && din_ready) begin
          if (idx % 2 == 1) begin
            wq.push_back('{idx / 2, int'({bytes[idx-1][3:0], bytes[idx]}), cyc + 1});
            if (idx / 2 == NS - 1) dq.push_back(cyc + 2);
          end
          idx++;
        end
        @(negedge clk);
        if (rst_at > 0 && idx == rst_at) begin
          reset_mid();
          return;
        end
        budget++;
        if (budget > 8 * NS + 20) begin
          check({nm, " load_bytes_accepted"}, idx, 2 * NS);
          break;
        end
      end
      din_valid = 1'b0;
      start     = 1'b0;
      for (int t = 0; t < 10 && n_done == d0; t++) @(negedge clk);
      #1;
      check({nm, " done_count"}, n_done - d0, 1);
      if (mode == 0) check({nm, " load_cycles"}, done_cyc - scyc, 3 * NS + 1);
      check({nm, " pending_writes"}, wq.size() + dq.size(), 0);
      @(negedge clk);
      check({nm, " idle_busy"}, int'(busy), 0);
      check({nm, " idle_din_ready"}, int'(din_ready), 0);
    endtask

    initial begin
      nm        = $sformatf("N%0d", NS);
      rst       = 1'b1;
      start     = 1'b0;
      din_valid = 1'b0;
      din       = 8'h00;
      @(negedge clk);
      check_zero("reset");
      @(negedge clk);
      rst = 1'b0;
    end

    if (k == 0) begin : t3
      initial begin
        repeat (3) @(negedge clk);
        bytes[0] = 8'h0A; bytes[1] = 8'hBC; bytes[2] = 8'h01;
        bytes[3] = 8'h23; bytes[4] = 8'hF4; bytes[5] = 8'h56;
        load(0, -1, 1'b0);
        fill_rand(); load(1, -1, 1'b0);
        fill_rand(); load(0, -1, 1'b1);
        fill_rand(); load(0, 3, 1'b0);
        fill_rand(); load(0, -1, 1'b0);
        for (int r = 0; r < 6; r++) begin
          fill_rand();
          load(2, -1, 1'(r % 2));
        end
        fin = 1'b1;
      end
    end else if (k == 1) begin : t1
      initial begin
        repeat (3) @(negedge clk);
        bytes[0] = 8'hFF; bytes[1] = 8'hFF;
        load(0, -1, 1'b0);
        for (int r = 0; r < 4; r++) begin
          fill_rand();
          load(2, -1, 1'b0);
        end
        fin = 1'b1;
      end
    end else begin : t4096
      initial begin
        repeat (3) @(negedge clk);
        fill_rand();
        load(0, -1, 1'b0);
        fin = 1'b1;
      end
    end
  end

  initial begin
    for (int t = 0; t < 40000; t++) begin
      if (g[0].fin && g[1].fin && g[2].fin) break;
      @(negedge clk);
    end
    check("all_sequences_finished", int'(g[0].fin && g[1].fin && g[2].fin), 1);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
